id_control_sequencer: RTL and testbench
=======================================

Name: id_control_sequencer

Overview:
Registered, multi-cycle-aware successor to the ID-stage combinational control decoder. Decodes each RV32IM instruction into the standard control bundle and registers it into the ID/EX boundary. It honours hazard-unit stall and flush, and holds the pipeline for parametrised-latency MUL/DIV operations. It sits between the IF/ID register and the EX stage, and drives the upstream stall for its own busy cycles.

Parameters:
DIV_LATENCY, 8, EX cycles for DIV/DIVU/REM/REMU (>=1)
MUL_LATENCY, 1, EX cycles for MUL/MULH/MULHSU/MULHU (>=1)
PC_WIDTH, 32, width of the pass-through PC

Ports:
clk  in  1  clock, rising edge
reset  in  1  async reset, active-low (asserted at 0)
in_valid  in  1  IF/ID holds a valid instruction
instr  in  32  instruction word
pc_in  in  PC_WIDTH  instruction PC
stall  in  1  hazard-unit freeze of ID/EX
flush  in  1  hazard/branch squash of ID/EX
out_valid  out  1  registered bundle is a real instruction
pc_out  out  PC_WIDTH  registered PC
alu_op  out  5  registered ALU op {alu_op[4] SUB/SRA/LUI, [3] M/LUI, [2:0] funct3 or 000}
reg_write_en  out  1  registered
mem_write  out  3  {store, funct3[1:0]}
mem_read  out  4  {load, funct3}
branch_jump  out  4  {branch/jump, JAL/JALR?010:funct3}
imm_sel  out  4  immediate type plus unsigned flag
data1_alu_sel  out  1  PC operand
data2_alu_sel  out  1  immediate operand
wb_sel  out  2  writeback mux select
busy_stall  out  1  combinational, high while a multi-cycle op occupies EX
ex_start  out  1  one-cycle pulse when a multi-cycle op enters EX

Behaviour:
- Decode mapping equals the team's RV32IM control encoding (shared encodings header). Outputs are registered, so latency is 1 cycle from instr to bundle.
- Reset (reset=0, async): all outputs 0, state RUN, counter 0. Outputs stay 0 until the first valid edge after release.
- Bubble means all control outputs 0, out_valid=0, and pc_out held.
- FSM states:
  - RUN, in_valid=1, op not multi-cycle: load the decoded bundle with out_valid=1.
  - RUN, in_valid=1, op multi-cycle (latency L>1): load the bundle, pulse ex_start, set cnt=L-1, go to BUSY.
  - RUN, in_valid=0: load a bubble.
  - BUSY: hold the bundle and keep busy_stall=1. cnt decrements each unstalled cycle. When cnt==1 and stall=0, the next edge returns to RUN and busy_stall drops. The next instruction is accepted only on the RUN edge.
- stall=1: all registers and cnt hold. busy_stall is unaffected.
- flush=1: load a bubble, force RUN, clear cnt. Flush beats stall and beats BUSY, including mid-operation.
- A multi-cycle op with L=1 behaves like a normal op: no BUSY state, but ex_start still pulses.
- NOP (opcode 0000000): reg_write_en=0, out_valid=1.
- Counter width: $clog2(max(DIV_LATENCY,MUL_LATENCY)+1). No wrap; the counter saturates at 0.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: adds output illegal_inst (1 bit, registered). Any unsupported opcode with in_valid=1 pulses illegal_inst for 1 cycle and loads a bubble. illegal_inst is cleared by flush or reset.
- Undefined: no port. An unsupported opcode decodes with reg_write_en=0, mem_write[2]=0, mem_read[3]=0, branch_jump[3]=0, out_valid=1.

Decomposition:
- Shared encodings header holds:
  - OP_* opcodes (R_TYPE, I_TYPE, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC)
  - IMM_TYPE1..6
  - FSM state constants ST_RUN, ST_BUSY
- One sub-module, id_decode_comb: pure combinational instr -> control bundle plus is_mul/is_div flags.
- id_control_sequencer owns the FSM, counter and ID/EX registers.

Test Plan:
- Reset: hold reset=0 with in_valid=1 and instr=0x002081B3. Expect all outputs 0. Release reset; the next edge gives out_valid=1, alu_op=00000, reg_write_en=1, wb_sel=01.
- DIV with DIV_LATENCY=8: instr=0x0220C1B3 (DIV x3,x1,x2). Expect ex_start for 1 cycle, busy_stall high for 7 cycles, and the bundle held with alu_op=01100. ADD 0x002081B3, presented throughout, loads on the 8th edge.
- Flush mid-DIV: assert flush at BUSY cycle 3. Expect the next edge to give out_valid=0, busy_stall=0, state RUN. The following ADD loads 1 cycle later.
- Stall during BUSY: stall=1 for 4 cycles at cycle 2. Expect busy_stall high for 7+4=11 cycles total and the bundle unchanged.
- Simultaneous stall=1 and flush=1 with LW 0x0000A183: expect a bubble (mem_read=0000), not the held bundle.
- ILLEGAL_TRAP_EN: instr=0x0000007F. With the macro defined, expect illegal_inst=1 for 1 cycle and out_valid=0. Without it, expect out_valid=1 and reg_write_en=0.

Source files
------------

// File: rtl/id_control_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// id_control_sequencer_pkg
// Shared RV32IM control encodings for the ID stage: opcodes, immediate-type
// codes, writeback-select codes, sequencer FSM states and the control bundle
// that travels across the ID/EX boundary.
// No ports (package). Optional feature macro used by the importers:
// ILLEGAL_TRAP_EN.
// -----------------------------------------------------------------------------
package id_control_sequencer_pkg;

    // Base opcodes (instr[6:0])
    localparam logic [6:0] OP_NOP    = 7'b0000000;
    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Immediate types; imm_sel = {unsigned_flag, IMM_TYPEn}
    localparam logic [2:0] IMM_TYPE1 = 3'd1;  // I-type
    localparam logic [2:0] IMM_TYPE2 = 3'd2;  // S-type
    localparam logic [2:0] IMM_TYPE3 = 3'd3;  // B-type
    localparam logic [2:0] IMM_TYPE4 = 3'd4;  // U-type
    localparam logic [2:0] IMM_TYPE5 = 3'd5;  // J-type
    localparam logic [2:0] IMM_TYPE6 = 3'd6;  // I-type shift amount

    // Writeback mux select
    localparam logic [1:0] WB_NONE = 2'b00;
    localparam logic [1:0] WB_ALU  = 2'b01;
    localparam logic [1:0] WB_MEM  = 2'b10;
    localparam logic [1:0] WB_PC4  = 2'b11;

    // JAL/JALR share one branch_jump code; 010 is not a conditional funct3
    localparam logic [3:0] BJ_JUMP = 4'b1010;

    // LUI is the only op with both upper ALU-op bits set
    localparam logic [4:0] ALU_LUI = 5'b11000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic [4:0] alu_op;
        logic       reg_write_en;
        logic [2:0] mem_write;
        logic [3:0] mem_read;
        logic [3:0] branch_jump;
        logic [3:0] imm_sel;
        logic       data1_alu_sel;
        logic       data2_alu_sel;
        logic [1:0] wb_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/id_decode_comb.sv
// -----------------------------------------------------------------------------
// id_decode_comb
// Pure combinational RV32IM decoder: instruction word -> control bundle, plus
// flags identifying M-extension multiply and divide/remainder operations and
// opcodes outside the supported set.
// Ports:
//   i_instr   in  32  instruction word
//   o_ctrl    out     decoded control bundle (ctrl_t)
//   o_is_mul  out  1  MUL/MULH/MULHSU/MULHU
//   o_is_div  out  1  DIV/DIVU/REM/REMU
//   o_illegal out  1  opcode not supported (all-zero NOP opcode is supported)
// -----------------------------------------------------------------------------
module id_decode_comb
    import id_control_sequencer_pkg::*;
(
    input  logic [31:0] i_instr,
    output ctrl_t       o_ctrl,
    output logic        o_is_mul,
    output logic        o_is_div,
    output logic        o_illegal
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_unused_fields;

    assign w_opcode        = i_instr[6:0];
    assign w_funct3        = i_instr[14:12];
    assign w_funct7        = i_instr[31:25];
    // Register indices and immediates are consumed by later stages
    assign w_unused_fields = ^{i_instr[24:15], i_instr[11:7]};

    always_comb begin
        o_ctrl    = CTRL_BUBBLE;
        o_is_mul  = 1'b0;
        o_is_div  = 1'b0;
        o_illegal = 1'b0;
        case (w_opcode)
            OP_NOP: begin
                // Everything stays zero; the sequencer still marks it valid
            end
            OP_R_TYPE: begin
                o_ctrl.reg_write_en = 1'b1;
                o_ctrl.wb_sel       = WB_ALU;
                o_ctrl.alu_op[2:0]  = w_funct3;
                if (w_funct7 == 7'b0000001) begin
                    o_ctrl.alu_op[3] = 1'b1;
                    o_is_mul         = ~w_funct3[2];
                    o_is_div         = w_funct3[2];
                end else begin
                    // SUB and SRA are the funct7[5] variants of ADD and SRL
                    o_ctrl.alu_op[4] = w_funct7[5] &
                                       ((w_funct3 == 3'b000) || (w_funct3 == 3'b101));
                end
            end
            OP_I_TYPE: begin
                o_ctrl.reg_write_en  = 1'b1;
                o_ctrl.wb_sel        = WB_ALU;
                o_ctrl.data2_alu_sel = 1'b1;
                o_ctrl.alu_op[2:0]   = w_funct3;
                o_ctrl.alu_op[4]     = (w_funct3 == 3'b101) & i_instr[30];
                if ((w_funct3 == 3'b001) || (w_funct3 == 3'b101)) begin
                    o_ctrl.imm_sel = {1'b0, IMM_TYPE6};
                end else begin
                    // SLTIU compares against the sign-extended imm as unsigned
                    o_ctrl.imm_sel = {(w_funct3 == 3'b011), IMM_TYPE1};
                end
            end
            OP_LOAD: begin
                o_ctrl.reg_write_en  = 1'b1;
                o_ctrl.wb_sel        = WB_MEM;
                o_ctrl.data2_alu_sel = 1'b1;
                o_ctrl.mem_read      = {1'b1, w_funct3};
                o_ctrl.imm_sel       = {w_funct3[2], IMM_TYPE1};
            end
            OP_STORE: begin
                o_ctrl.data2_alu_sel = 1'b1;
                o_ctrl.mem_write     = {1'b1, w_funct3[1:0]};
                o_ctrl.imm_sel       = {1'b0, IMM_TYPE2};
            end
            OP_BRANCH: begin
                o_ctrl.branch_jump = {1'b1, w_funct3};
                // funct3[1] set selects BLTU/BGEU
                o_ctrl.imm_sel     = {w_funct3[1], IMM_TYPE3};
            end
            OP_JAL: begin
                o_ctrl.reg_write_en  = 1'b1;
                o_ctrl.wb_sel        = WB_PC4;
                o_ctrl.branch_jump   = BJ_JUMP;
                o_ctrl.data1_alu_sel = 1'b1;
                o_ctrl.data2_alu_sel = 1'b1;
                o_ctrl.imm_sel       = {1'b0, IMM_TYPE5};
            end
            OP_JALR: begin
                o_ctrl.reg_write_en  = 1'b1;
                o_ctrl.wb_sel        = WB_PC4;
                o_ctrl.branch_jump   = BJ_JUMP;
                o_ctrl.data2_alu_sel = 1'b1;
                o_ctrl.imm_sel       = {1'b0, IMM_TYPE1};
            end
            OP_LUI: begin
                o_ctrl.reg_write_en  = 1'b1;
                o_ctrl.wb_sel        = WB_ALU;
                o_ctrl.alu_op        = ALU_LUI;
                o_ctrl.data2_alu_sel = 1'b1;
                o_ctrl.imm_sel       = {1'b0, IMM_TYPE4};
            end
            OP_AUIPC: begin
                o_ctrl.reg_write_en  = 1'b1;
                o_ctrl.wb_sel        = WB_ALU;
                o_ctrl.data1_alu_sel = 1'b1;
                o_ctrl.data2_alu_sel = 1'b1;
                o_ctrl.imm_sel       = {1'b0, IMM_TYPE4};
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_control_sequencer.sv
// -----------------------------------------------------------------------------
// id_control_sequencer
// Registered ID-stage control: decodes each instruction into the control
// bundle and registers it into ID/EX. Honours hazard stall/flush and holds the
// pipeline (busy_stall) while a multi-cycle MUL/DIV occupies EX.
// Optional feature macro: ILLEGAL_TRAP_EN (adds o_illegal_inst; unsupported
// opcodes then load a bubble instead of a valid no-effect bundle).
// Ports:
//   i_clk, i_rst_n (async, active-low)
//   i_in_valid, i_instr[31:0], i_pc[PC_WIDTH-1:0], i_stall, i_flush
//   o_out_valid, o_pc, o_alu_op[4:0], o_reg_write_en, o_mem_write[2:0],
//   o_mem_read[3:0], o_branch_jump[3:0], o_imm_sel[3:0], o_data1_alu_sel,
//   o_data2_alu_sel, o_wb_sel[1:0]          registered ID/EX bundle
//   o_busy_stall  combinational, high while in BUSY
//   o_ex_start    one-cycle pulse when a MUL/DIV enters EX
//   o_illegal_inst (ILLEGAL_TRAP_EN only) one-cycle pulse on illegal opcode
// -----------------------------------------------------------------------------
module id_control_sequencer
    import id_control_sequencer_pkg::*;
#(
    parameter int unsigned DIV_LATENCY = 8,
    parameter int unsigned MUL_LATENCY = 1,
    parameter int unsigned PC_WIDTH    = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_in_valid,
    input  logic [31:0]         i_instr,
    input  logic [PC_WIDTH-1:0] i_pc,
    input  logic                i_stall,
    input  logic                i_flush,
    output logic                o_out_valid,
    output logic [PC_WIDTH-1:0] o_pc,
    output logic [4:0]          o_alu_op,
    output logic                o_reg_write_en,
    output logic [2:0]          o_mem_write,
    output logic [3:0]          o_mem_read,
    output logic [3:0]          o_branch_jump,
    output logic [3:0]          o_imm_sel,
    output logic                o_data1_alu_sel,
    output logic                o_data2_alu_sel,
    output logic [1:0]          o_wb_sel,
    output logic                o_busy_stall,
`ifdef ILLEGAL_TRAP_EN
    output logic                o_illegal_inst,
`endif
    output logic                o_ex_start
);

    localparam int unsigned MAX_LAT = max_u(DIV_LATENCY, MUL_LATENCY);
    localparam int          CNT_W   = $clog2(MAX_LAT + 1);

    // Decoder outputs
    ctrl_t              w_dec_ctrl;
    logic               w_is_mul;
    logic               w_is_div;
    logic               w_dec_illegal;
    logic               w_is_multi;
    logic               w_enter_busy;
    logic [CNT_W-1:0]   w_lat_m1;

    // ID/EX registers and their next values
    state_e             r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    ctrl_t              r_ctrl, w_ctrl_next;
    logic               r_valid, w_valid_next;
    logic [PC_WIDTH-1:0] r_pc, w_pc_next;
    logic               r_ex_start, w_ex_start_next;
`ifdef ILLEGAL_TRAP_EN
    logic               r_illegal, w_illegal_next;
`else
    logic               w_unused_illegal;
    assign w_unused_illegal = w_dec_illegal;
`endif

    id_decode_comb u_decode (
        .i_instr   (i_instr),
        .o_ctrl    (w_dec_ctrl),
        .o_is_mul  (w_is_mul),
        .o_is_div  (w_is_div),
        .o_illegal (w_dec_illegal)
    );

    assign w_is_multi   = w_is_mul | w_is_div;
    // Latency-1 ops pulse ex_start but never enter BUSY
    assign w_enter_busy = (w_is_div && (DIV_LATENCY > 1)) ||
                          (w_is_mul && (MUL_LATENCY > 1));
    assign w_lat_m1     = w_is_div ? CNT_W'(DIV_LATENCY - 1) : CNT_W'(MUL_LATENCY - 1);

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_ctrl_next     = r_ctrl;
        w_valid_next    = r_valid;
        w_pc_next       = r_pc;
        // Pulses drop on every edge that does not re-launch them, stalled or
        // not, so downstream never sees a start or trap twice
        w_ex_start_next = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        w_illegal_next  = 1'b0;
`endif
        if (i_flush) begin
            w_state_next = ST_RUN;
            w_cnt_next   = '0;
            w_ctrl_next  = CTRL_BUBBLE;
            w_valid_next = 1'b0;
        end else if (i_stall) begin
            // Freeze bundle, state and counter
        end else if (r_state == ST_BUSY) begin
            // Bundle held; leaving BUSY does not accept the next instruction,
            // because IF/ID was still frozen by busy_stall on this edge
            if (r_cnt <= CNT_W'(1)) begin
                w_state_next = ST_RUN;
                w_cnt_next   = '0;
            end else begin
                w_cnt_next = r_cnt - CNT_W'(1);
            end
        end else if (!i_in_valid) begin
            w_ctrl_next  = CTRL_BUBBLE;
            w_valid_next = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        end else if (w_dec_illegal) begin
            w_ctrl_next    = CTRL_BUBBLE;
            w_valid_next   = 1'b0;
            w_illegal_next = 1'b1;
`endif
        end else begin
            w_ctrl_next     = w_dec_ctrl;
            w_valid_next    = 1'b1;
            w_pc_next       = i_pc;
            w_ex_start_next = w_is_multi;
            if (w_enter_busy) begin
                w_state_next = ST_BUSY;
                w_cnt_next   = w_lat_m1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_RUN;
            r_cnt      <= '0;
            r_ctrl     <= CTRL_BUBBLE;
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_ex_start <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            r_illegal  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_ctrl     <= w_ctrl_next;
            r_valid    <= w_valid_next;
            r_pc       <= w_pc_next;
            r_ex_start <= w_ex_start_next;
`ifdef ILLEGAL_TRAP_EN
            r_illegal  <= w_illegal_next;
`endif
        end
    end

    assign o_out_valid     = r_valid;
    assign o_pc            = r_pc;
    assign o_alu_op        = r_ctrl.alu_op;
    assign o_reg_write_en  = r_ctrl.reg_write_en;
    assign o_mem_write     = r_ctrl.mem_write;
    assign o_mem_read      = r_ctrl.mem_read;
    assign o_branch_jump   = r_ctrl.branch_jump;
    assign o_imm_sel       = r_ctrl.imm_sel;
    assign o_data1_alu_sel = r_ctrl.data1_alu_sel;
    assign o_data2_alu_sel = r_ctrl.data2_alu_sel;
    assign o_wb_sel        = r_ctrl.wb_sel;
    assign o_busy_stall    = (r_state == ST_BUSY);
    assign o_ex_start      = r_ex_start;
`ifdef ILLEGAL_TRAP_EN
    assign o_illegal_inst  = r_illegal;
`endif

endmodule

// File: tb/tb_id_control_sequencer.sv
module tb_id_control_sequencer;

    localparam int DIV_LAT = 8;
    localparam int MUL_LAT = 1;
    localparam int PCW     = 32;
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_DIV = 32'h0220C1B3;
    localparam logic [31:0] I_LW  = 32'h0000A183;
    localparam logic [31:0] I_ILL = 32'h0000007F;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           in_valid = 1'b0;
    logic [31:0]    instr = '0;
    logic [PCW-1:0] pc_in = '0;
    logic           stall = 1'b0;
    logic           flush = 1'b0;
    logic           out_valid;
    logic [PCW-1:0] pc_out;
    logic [4:0]     alu_op;
    logic           reg_write_en;
    logic [2:0]     mem_write;
    logic [3:0]     mem_read;
    logic [3:0]     branch_jump;
    logic [3:0]     imm_sel;
    logic           data1_alu_sel;
    logic           data2_alu_sel;
    logic [1:0]     wb_sel;
    logic           busy_stall;
    logic           ex_start;
    logic           illegal_inst;

    always #5 clk = ~clk;

    id_control_sequencer #(
        .DIV_LATENCY (DIV_LAT),
        .MUL_LATENCY (MUL_LAT),
        .PC_WIDTH    (PCW)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_in_valid      (in_valid),
        .i_instr         (instr),
        .i_pc            (pc_in),
        .i_stall         (stall),
        .i_flush         (flush),
        .o_out_valid     (out_valid),
        .o_pc            (pc_out),
        .o_alu_op        (alu_op),
        .o_reg_write_en  (reg_write_en),
        .o_mem_write     (mem_write),
        .o_mem_read      (mem_read),
        .o_branch_jump   (branch_jump),
        .o_imm_sel       (imm_sel),
        .o_data1_alu_sel (data1_alu_sel),
        .o_data2_alu_sel (data2_alu_sel),
        .o_wb_sel        (wb_sel),
        .o_busy_stall    (busy_stall),
`ifdef ILLEGAL_TRAP_EN
        .o_illegal_inst  (illegal_inst),
`endif
        .o_ex_start      (ex_start)
    );
`ifndef ILLEGAL_TRAP_EN
    assign illegal_inst = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state: what ID/EX should hold after each edge
    logic [24:0]    m_ctrl;
    logic           m_valid;
    logic [PCW-1:0] m_pc;
    logic           m_ex;
    logic           m_ill;
    int             m_busy_left;

    logic [24:0] dut_ctrl;
    assign dut_ctrl = {alu_op, reg_write_en, mem_write, mem_read, branch_jump,
                       imm_sel, data1_alu_sel, data2_alu_sel, wb_sel};

    // Bundle layout: {alu_op, rwe, mem_write, mem_read, branch_jump, imm_sel, d1, d2, wb}
    // Returns {illegal, bundle}
    function automatic logic [25:0] ref_decode(input logic [31:0] ins);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_aui;
        logic [4:0] alu;
        logic rwe, d1, d2, ill;
        logic [2:0] mw;
        logic [3:0] mr, bj, imm;
        logic [1:0] wb;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        is_r = (op == 7'h33); is_i = (op == 7'h13); is_ld = (op == 7'h03);
        is_st = (op == 7'h23); is_br = (op == 7'h63); is_jal = (op == 7'h6F);
        is_jalr = (op == 7'h67); is_lui = (op == 7'h37); is_aui = (op == 7'h17);
        ill = !(is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_aui)
              && (op != 7'h00);
        rwe = is_r | is_i | is_ld | is_jal | is_jalr | is_lui | is_aui;
        wb  = is_ld ? 2'd2 : (is_jal | is_jalr) ? 2'd3 : (is_r | is_i | is_lui | is_aui) ? 2'd1 : 2'd0;
        mw  = is_st ? {1'b1, f3[1:0]} : 3'd0;
        mr  = is_ld ? {1'b1, f3} : 4'd0;
        bj  = is_br ? {1'b1, f3} : (is_jal | is_jalr) ? 4'b1010 : 4'd0;
        d1  = is_aui | is_jal;
        d2  = is_i | is_ld | is_st | is_jal | is_jalr | is_lui | is_aui;
        imm = 4'd0;
        if (is_i)   imm = (f3 == 3'd1 || f3 == 3'd5) ? 4'd6 : {(f3 == 3'd3), 3'd1};
        if (is_ld)  imm = {f3[2], 3'd1};
        if (is_st)  imm = 4'd2;
        if (is_br)  imm = {f3[1], 3'd3};
        if (is_lui || is_aui) imm = 4'd4;
        if (is_jal)  imm = 4'd5;
        if (is_jalr) imm = 4'd1;
        alu = 5'd0;
        if (is_r)   alu = (f7 == 7'h01) ? {2'b01, f3}
                        : {f7[5] && (f3 == 3'd0 || f3 == 3'd5), 1'b0, f3};
        if (is_i)   alu = {(f3 == 3'd5) && ins[30], 1'b0, f3};
        if (is_lui) alu = 5'b11000;
        return {ill, alu, rwe, mw, mr, bj, imm, d1, d2, wb};
    endfunction

    // EX occupancy in cycles for M-extension ops, 0 for everything else
    function automatic int ref_latency(input logic [31:0] ins);
        if (ins[6:0] == 7'h33 && ins[31:25] == 7'h01)
            return ins[14] ? DIV_LAT : MUL_LAT;
        return 0;
    endfunction

    task automatic model_reset();
        m_ctrl = '0; m_valid = 1'b0; m_pc = '0; m_ex = 1'b0; m_ill = 1'b0; m_busy_left = 0;
    endtask

    task automatic model_edge();
        logic [25:0] d;
        int lat;
        if (!rst_n) begin
            model_reset();
        end else if (flush) begin
            m_ctrl = '0; m_valid = 1'b0; m_ex = 1'b0; m_ill = 1'b0; m_busy_left = 0;
        end else if (stall) begin
            m_ex = 1'b0; m_ill = 1'b0;
        end else if (m_busy_left > 0) begin
            m_busy_left--; m_ex = 1'b0; m_ill = 1'b0;
        end else begin
            m_ex = 1'b0; m_ill = 1'b0;
            d = ref_decode(instr);
            if (!in_valid) begin
                m_ctrl = '0; m_valid = 1'b0;
            end else if (d[25] && TRAP) begin
                m_ctrl = '0; m_valid = 1'b0; m_ill = 1'b1;
            end else begin
                lat = ref_latency(instr);
                m_ctrl = d[24:0]; m_valid = 1'b1; m_pc = pc_in;
                m_ex = (lat > 0);
                m_busy_left = (lat > 0) ? lat - 1 : 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 13);
        case (k)
            0:  begin
                    case ($urandom_range(0, 2))
                        0: r[31:25] = 7'h00;
                        1: r[31:25] = 7'h20;
                        default: r[31:25] = 7'h01;
                    endcase
                    return {r[31:7], 7'h33};
                end
            1:  return {r[31:7], 7'h13};
            2:  return {r[31:7], 7'h03};
            3:  return {r[31:7], 7'h23};
            4:  return {r[31:7], 7'h63};
            5:  return {r[31:7], 7'h6F};
            6:  return {r[31:7], 7'h67};
            7:  return {r[31:7], 7'h37};
            8:  return {r[31:7], 7'h17};
            9:  return {r[31:7], 7'h00};
            10: return {r[31:7], 7'h7F};
            default: return {7'h01, r[24:7], 7'h33};
        endcase
    endfunction

    task automatic test_reset();
        in_valid = 1'b1; instr = I_ADD; pc_in = 32'h100; stall = 1'b0; flush = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        tick(); tick();
        checks++;
        if ({out_valid, pc_out, dut_ctrl, busy_stall, ex_start, illegal_inst} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b pc=%h ctrl=%h busy=%b ex=%b ill=%b, want all 0",
                     out_valid, pc_out, dut_ctrl, busy_stall, ex_start, illegal_inst);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({out_valid, alu_op, reg_write_en, wb_sel, pc_out} !== {1'b1, 5'b00000, 1'b1, 2'b01, 32'h100}) begin
            errors++;
            $display("FAIL reset_first_add: got valid=%b alu=%b rwe=%b wb=%b pc=%h, want 1 00000 1 01 00000100",
                     out_valid, alu_op, reg_write_en, wb_sel, pc_out);
        end
        $display("reset: released, ADD bundle valid=%b alu=%b", out_valid, alu_op);
    endtask

    task automatic test_div();
        int n_busy;
        int n_ex;
        in_valid = 1'b1; instr = I_DIV; pc_in = 32'h200;
        tick();
        instr = I_ADD; pc_in = 32'h204;
        n_busy = 0; n_ex = 0;
        while (busy_stall && n_busy < 30) begin
            n_busy++;
            if (ex_start) n_ex++;
            checks++;
            if ({alu_op, out_valid, pc_out} !== {5'b01100, 1'b1, 32'h200}) begin
                errors++;
                $display("FAIL div_hold: cycle %0d got alu=%b valid=%b pc=%h, want 01100 1 00000200",
                         n_busy, alu_op, out_valid, pc_out);
            end
            tick();
        end
        checks++;
        if (n_busy != DIV_LAT - 1 || n_ex != 1) begin
            errors++;
            $display("FAIL div_busy_len: got busy=%0d ex_start=%0d, want busy=%0d ex_start=1",
                     n_busy, n_ex, DIV_LAT - 1);
        end
        checks++;
        if ({alu_op, pc_out} !== {5'b01100, 32'h200}) begin
            errors++;
            $display("FAIL div_exit_hold: got alu=%b pc=%h, want 01100 00000200", alu_op, pc_out);
        end
        tick();
        checks++;
        if ({out_valid, alu_op, pc_out, busy_stall} !== {1'b1, 5'b00000, 32'h204, 1'b0}) begin
            errors++;
            $display("FAIL div_next_add: got valid=%b alu=%b pc=%h busy=%b, want 1 00000 00000204 0",
                     out_valid, alu_op, pc_out, busy_stall);
        end
        $display("div: busy cycles=%0d ex_start pulses=%0d", n_busy, n_ex);
    endtask

    task automatic test_flush_mid_div();
        in_valid = 1'b1; instr = I_DIV; pc_in = 32'h300;
        tick();
        instr = I_ADD; pc_in = 32'h304;
        tick(); tick();
        checks++;
        if (busy_stall !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre_busy: got busy=%b, want 1", busy_stall);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if ({out_valid, busy_stall, dut_ctrl, pc_out} !== {1'b0, 1'b0, 25'd0, 32'h300}) begin
            errors++;
            $display("FAIL flush_bubble: got valid=%b busy=%b ctrl=%h pc=%h, want 0 0 0 00000300",
                     out_valid, busy_stall, dut_ctrl, pc_out);
        end
        tick();
        checks++;
        if ({out_valid, alu_op, pc_out} !== {1'b1, 5'b00000, 32'h304}) begin
            errors++;
            $display("FAIL flush_next_add: got valid=%b alu=%b pc=%h, want 1 00000 00000304",
                     out_valid, alu_op, pc_out);
        end
        $display("flush_mid_div: bubble then ADD pc=%h", pc_out);
    endtask

    task automatic test_stall_busy();
        int n_busy;
        in_valid = 1'b1; instr = I_DIV; pc_in = 32'h400;
        tick();
        instr = I_ADD; pc_in = 32'h404;
        n_busy = 0;
        while (busy_stall && n_busy < 40) begin
            n_busy++;
            stall = (n_busy >= 2 && n_busy <= 5);
            checks++;
            if ({alu_op, out_valid, pc_out} !== {5'b01100, 1'b1, 32'h400}) begin
                errors++;
                $display("FAIL stall_busy_hold: cycle %0d got alu=%b valid=%b pc=%h, want 01100 1 00000400",
                         n_busy, alu_op, out_valid, pc_out);
            end
            tick();
        end
        stall = 1'b0;
        checks++;
        if (n_busy != DIV_LAT - 1 + 4) begin
            errors++;
            $display("FAIL stall_busy_len: got %0d busy cycles, want %0d", n_busy, DIV_LAT - 1 + 4);
        end
        tick();
        checks++;
        if ({out_valid, alu_op, pc_out} !== {1'b1, 5'b00000, 32'h404}) begin
            errors++;
            $display("FAIL stall_busy_next: got valid=%b alu=%b pc=%h, want 1 00000 00000404",
                     out_valid, alu_op, pc_out);
        end
        $display("stall_busy: busy cycles=%0d", n_busy);
    endtask

    task automatic test_stall_flush();
        in_valid = 1'b1; instr = I_ADD; pc_in = 32'h500;
        tick();
        instr = I_LW; pc_in = 32'h504; stall = 1'b1;
        tick();
        checks++;
        if ({out_valid, alu_op, mem_read, pc_out} !== {1'b1, 5'b00000, 4'b0000, 32'h500}) begin
            errors++;
            $display("FAIL stall_hold: got valid=%b alu=%b mr=%b pc=%h, want 1 00000 0000 00000500",
                     out_valid, alu_op, mem_read, pc_out);
        end
        flush = 1'b1;
        tick();
        checks++;
        if ({out_valid, mem_read, dut_ctrl} !== {1'b0, 4'b0000, 25'd0}) begin
            errors++;
            $display("FAIL stall_flush_bubble: got valid=%b mr=%b ctrl=%h, want 0 0000 0",
                     out_valid, mem_read, dut_ctrl);
        end
        stall = 1'b0; flush = 1'b0;
        tick();
        checks++;
        if ({out_valid, mem_read, wb_sel, reg_write_en, pc_out} !== {1'b1, 4'b1010, 2'b10, 1'b1, 32'h504}) begin
            errors++;
            $display("FAIL lw_load: got valid=%b mr=%b wb=%b rwe=%b pc=%h, want 1 1010 10 1 00000504",
                     out_valid, mem_read, wb_sel, reg_write_en, pc_out);
        end
        $display("stall_flush: LW mem_read=%b", mem_read);
    endtask

    task automatic test_illegal();
        in_valid = 1'b1; instr = I_ILL; pc_in = 32'h600;
        tick();
        instr = I_ADD; pc_in = 32'h604;
        checks++;
        if (TRAP) begin
            if ({illegal_inst, out_valid} !== 2'b10) begin
                errors++;
                $display("FAIL illegal_trap: got ill=%b valid=%b, want 1 0", illegal_inst, out_valid);
            end
        end else begin
            if ({out_valid, reg_write_en, mem_write[2], mem_read[3], branch_jump[3]} !== 5'b10000) begin
                errors++;
                $display("FAIL illegal_decode: got valid=%b rwe=%b mw2=%b mr3=%b bj3=%b, want 1 0 0 0 0",
                         out_valid, reg_write_en, mem_write[2], mem_read[3], branch_jump[3]);
            end
        end
        tick();
        checks++;
        if ({illegal_inst, out_valid, pc_out} !== {1'b0, 1'b1, 32'h604}) begin
            errors++;
            $display("FAIL illegal_clear: got ill=%b valid=%b pc=%h, want 0 1 00000604",
                     illegal_inst, out_valid, pc_out);
        end
        $display("illegal: trap build=%b", TRAP);
    endtask

    task automatic test_random();
        logic [60:0] exp_v;
        logic [60:0] got_v;
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(0, 9) != 0);
            instr    = rand_instr();
            pc_in    = $urandom;
            stall    = ($urandom_range(0, 9) == 0);
            flush    = ($urandom_range(0, 24) == 0);
            tick();
            exp_v = {m_valid, m_pc, m_ctrl, (m_busy_left > 0), m_ex, m_ill};
            got_v = {out_valid, pc_out, dut_ctrl, busy_stall, ex_start, illegal_inst};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random_cycle %0d: instr=%h got=%h want=%h", i, instr, got_v, exp_v);
            end
        end
        stall = 1'b0; flush = 1'b0;
        $display("random: 600 cycles compared against reference model");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_div();
        test_flush_mid_div();
        test_stall_busy();
        test_stall_flush();
        test_illegal();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
